// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detector controller.
// Loads a PAT_W-bit target pattern serially (MSB first), then, while armed,
// watches a qualified bit stream. A match pulses hit for one cycle, bumps a
// saturating hit counter and holds the "8." segment pattern for HOLD_CYCLES.
//
// Build option: define SEQCTRL_OVERLAP_EN to keep detecting during HOLD
// (overlapping matches counted, hold window restarted on each match).
// Without it, bits are ignored during HOLD and the history restarts on exit.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   cfg_load   start pattern programming (strobe)
//   cfg_valid  cfg_bit qualifier
//   cfg_bit    pattern bit, MSB first
//   arm        detection enable (level)
//   bit_valid  bit_in qualifier
//   bit_in     serial stream bit
//   cnt_clr    synchronous clear of hit_count (wins over increment)
//   hit        one-cycle pulse per match
//   hit_count  saturating match count
//   state_o    FSM state (IDLE=0, LOAD=1, ARMED=2, HOLD=3)
//   seg        segment pattern
module seq_detect_ctrl #(
   parameter int unsigned PAT_W       = 4,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_load,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   input  logic             arm,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             cnt_clr,
   output logic             hit,
   output logic [CNT_W-1:0] hit_count,
   output logic [1:0]       state_o,
   output logic [7:0]       seg
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [7:0] SEG_IDLE = 8'b0000_0010;
   localparam logic [7:0] SEG_LOAD = 8'b0000_0000;
   localparam logic [7:0] SEG_HOLD = 8'b1111_1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARMED = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t              r_state;
   logic [PAT_W-1:0]    r_pattern;
   logic [PAT_W-1:0]    r_hist;
   logic [FILL_W-1:0]   r_fill;
   logic [FILL_W-1:0]   r_load_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_hit;
   logic [CNT_W-1:0]    r_hit_count;
   logic [7:0]          r_seg;

   state_t              w_state_nxt;
   logic [7:0]          w_seg_nxt;
   logic [PAT_W-1:0]    w_hist_shift;
   logic [FILL_W-1:0]   w_fill_inc;
   logic                w_shift_en;
   logic                w_match;
   logic                w_hold_done;
   logic                w_load_last;

   // Match datapath: evaluated on the history/fill as they will be after this edge
   always_comb begin
      w_hist_shift = {r_hist[PAT_W-2:0], bit_in};
      w_fill_inc   = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
`ifdef SEQCTRL_OVERLAP_EN
      w_shift_en   = bit_valid && ((r_state == ST_ARMED) || (r_state == ST_HOLD));
`else
      w_shift_en   = bit_valid && (r_state == ST_ARMED);
`endif
      w_match      = w_shift_en && (w_fill_inc == FILL_W'(PAT_W)) && (w_hist_shift == r_pattern);
      w_hold_done  = (r_hold_cnt == '0);
      w_load_last  = !cfg_load && cfg_valid && (r_load_cnt == FILL_W'(PAT_W - 1));
   end

   // Next-state and next segment pattern
   always_comb begin
      w_state_nxt = r_state;
      w_seg_nxt   = SEG_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (cfg_load)  w_state_nxt = ST_LOAD;
            else if (arm)  w_state_nxt = ST_ARMED;
         end
         ST_LOAD: begin
            if (w_load_last) w_state_nxt = ST_IDLE;
         end
         ST_ARMED: begin
            if (w_match)   w_state_nxt = ST_HOLD;
            else if (!arm) w_state_nxt = ST_IDLE;
         end
         ST_HOLD: begin
            // A re-trigger (overlap build only) keeps us in HOLD
            if (!w_match && w_hold_done) w_state_nxt = arm ? ST_ARMED : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      case (w_state_nxt)
         ST_HOLD: w_seg_nxt = SEG_HOLD;
         ST_LOAD: w_seg_nxt = SEG_LOAD;
         default: w_seg_nxt = SEG_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_pattern   <= '0;
         r_hist      <= '0;
         r_fill      <= '0;
         r_load_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_hit       <= 1'b0;
         r_hit_count <= '0;
         r_seg       <= SEG_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_seg   <= w_seg_nxt;
         r_hit   <= w_match;

         if (cnt_clr)                            r_hit_count <= '0;
         else if (w_match && (r_hit_count != '1)) r_hit_count <= r_hit_count + CNT_W'(1);

         case (r_state)
            ST_IDLE: begin
               if (cfg_load) begin
                  r_load_cnt <= '0;
               end else if (arm) begin
                  r_hist <= '0;
                  r_fill <= '0;
               end
            end
            ST_LOAD: begin
               // A fresh cfg_load restarts programming; its cfg_bit is dropped
               if (cfg_load) begin
                  r_load_cnt <= '0;
               end else if (cfg_valid) begin
                  r_pattern  <= {r_pattern[PAT_W-2:0], cfg_bit};
                  r_load_cnt <= w_load_last ? '0 : r_load_cnt + FILL_W'(1);
               end
            end
            default: ;
         endcase

         if (w_shift_en) begin
            r_hist <= w_hist_shift;
            r_fill <= w_fill_inc;
         end

         if (w_match) begin
            r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
         end else if (r_state == ST_HOLD) begin
            if (!w_hold_done) begin
               r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
`ifndef SEQCTRL_OVERLAP_EN
            else begin
               // Non-overlapping: next match needs PAT_W fresh bits
               r_hist <= '0;
               r_fill <= '0;
            end
`endif
         end
      end
   end

   assign hit       = r_hit;
   assign hit_count = r_hit_count;
   assign state_o   = r_state;
   assign seg       = r_seg;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable controller that sequences serial-pattern detection and drives the 7-segment output (uo_out path).
- Loads a PAT_W-bit target pattern serially, then arms and watches a validated bit stream.
- Each match raises a one-cycle hit pulse, bumps a saturating hit counter, and holds the "8." display for a fixed number of cycles.
- Sits between the ui_in pin decode and the segment driver; replaces the fixed-pattern detector path.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..8).
- HOLD_CYCLES, 8, cycles the detect display is held after a match (legal minimum 1).
- CNT_W, 4, hit counter width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- cfg_load  input  1  start pattern programming (one-cycle strobe).
- cfg_valid  input  1  cfg_bit qualifier.
- cfg_bit  input  1  pattern bit, MSB first.
- arm  input  1  level; detection enabled while high.
- bit_valid  input  1  bit_in qualifier.
- bit_in  input  1  serial stream bit.
- cnt_clr  input  1  synchronous clear of hit_count.
- hit  output  1  registered one-cycle pulse per match.
- hit_count  output  CNT_W  saturating match count.
- state_o  output  2  FSM state (IDLE=0, LOAD=1, ARMED=2, HOLD=3).
- seg  output  8  segment pattern.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; pattern=0; history=0; fill=0; load count=0; hold count=0; hit=0; hit_count=0; seg=8'b00000010. All registers are synchronous; there is no asynchronous path.
- seg is registered from next state:
  - HOLD: 8'b11111111.
  - LOAD: 8'b00000000.
  - IDLE/ARMED: 8'b00000010.
- IDLE:
  - cfg_load=1 -> LOAD, load count=0.
  - Else arm=1 -> ARMED, history=0, fill=0.
  - cfg_load has priority over arm.
- LOAD:
  - Each cycle with cfg_valid=1: pattern <= {pattern[PAT_W-2:0], cfg_bit}, load count+1.
  - On the edge accepting the PAT_W-th bit -> IDLE.
  - cfg_load=1 while in LOAD restarts the count (the bit on that same cycle is ignored).
  - arm is ignored in LOAD.
- ARMED:
  - Each bit_valid=1 cycle: history <= {history[PAT_W-2:0], bit_in}; fill saturates at PAT_W.
  - Match is evaluated on the updated history and requires updated fill==PAT_W.
  - On a match, at the same edge that samples the final bit: hit=1; hit_count+1 (saturates at 2^CNT_W-1); state HOLD; hold count=HOLD_CYCLES-1.
  - arm=0 with no match -> IDLE. A match on that same cycle still counts and enters HOLD.
  - cfg_load is ignored.
- HOLD:
  - hit=0 unless re-triggered (see Optional Feature).
  - Hold count decrements each cycle. At hold count==0: -> ARMED if arm=1, else IDLE.
  - HOLD always lasts HOLD_CYCLES cycles; arm=0 does not abort it.
  - cfg_load is ignored.
- Latency: final matching bit at edge N -> hit high for exactly the cycle after edge N; seg shows 8'hFF for HOLD_CYCLES cycles starting there.
- cnt_clr=1: hit_count <= 0. Clear wins over a simultaneous increment.
- hit is 0 in every state except the cycle following a match edge.
- Reset mid-LOAD: the partial pattern is discarded (pattern=0).
- Pattern is retained across arm/disarm cycles until reprogrammed or reset.

Optional Feature:
- Macro: SEQCTRL_OVERLAP_EN.
- Defined:
  - History keeps shifting on bit_valid during HOLD; fill is retained after a match.
  - A match during HOLD pulses hit, increments hit_count and reloads hold count to HOLD_CYCLES-1.
  - Overlapping occurrences are all counted.
- Undefined:
  - bit_valid is ignored in HOLD.
  - On HOLD exit, history=0 and fill=0, so the next match needs PAT_W fresh bits (non-overlapping).

Test Plan:
- Reset: hold reset=0 for 2 cycles with inputs toggling -> state_o=0, hit=0, hit_count=0, seg=8'b00000010.
- Program 1011 (cfg_valid gapped by idle cycles), arm=1, stream 1,0,1,1 -> hit pulse 1 cycle after the 4th bit, hit_count=1, seg=8'hFF for 8 cycles, then ARMED with seg=8'b00000010.
- Pattern 1010, stream 1,0,1,0,1,0:
  - Overlap build: 2 hits, hit_count=2, HOLD extended to 8 cycles after the second hit.
  - Non-overlap build: 1 hit; bits 5–6 are ignored.
- Arm with pattern 1111, stream only 3 ones then arm=0 -> IDLE, no hit. Re-arm and send a single 1 -> no hit (history cleared).
- Saturation/clear: force 16 matches -> hit_count=15 stays 15. cnt_clr on the same cycle as a match edge -> hit_count=0, hit still pulses.
- cfg_load asserted during ARMED and HOLD -> ignored. reset=0 mid-LOAD after 2 bits -> pattern=0, state IDLE.
